// File: rtl/rr_priority_arbiter_pkg.sv
// Shared definitions for the registered priority arbiter and its relatives
// (the combinational priority encoder uses clogb2 as well).
package rr_priority_arbiter_pkg;

    // Number of bits needed to hold the value v (v >= 1 returns at least 1).
    function automatic int clogb2(input int v);
        int n;
        int x;
        n = 0;
        x = v;
        while (x > 0) begin
            n = n + 1;
            x = x >> 1;
        end
        if (n == 0) begin
            n = 1;
        end
        return n;
    endfunction

    // Arbiter FSM encoding: IDLE presents nothing, GRANT presents a held grant.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_priority_arbiter_if.sv
// Request/grant bus between requesters, the arbiter and the grant consumer.
//
// Handshake: a grant transfers on a rising clk edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low the
// arbiter holds grant_onehot/grant_idx stable; out_valid never drops without
// a transfer or a reset. grant_ack is the same-cycle transfer pulse per
// requester, and any_req is the OR of the request vector.
interface rr_priority_arbiter_if #(
    parameter int NUM_REQ   = 16,
    parameter int IDX_WIDTH = rr_priority_arbiter_pkg::clogb2(NUM_REQ - 1)
) ();

    logic [NUM_REQ-1:0]   req;
    logic                 out_valid;
    logic                 out_ready;
    logic [NUM_REQ-1:0]   grant_onehot;
    logic [IDX_WIDTH-1:0] grant_idx;
    logic [NUM_REQ-1:0]   grant_ack;
    logic                 any_req;

    // Arbiter side.
    modport master (
        input  req,
        input  out_ready,
        output out_valid,
        output grant_onehot,
        output grant_idx,
        output grant_ack,
        output any_req
    );

    // Requester/consumer side.
    modport slave (
        output req,
        output out_ready,
        input  out_valid,
        input  grant_onehot,
        input  grant_idx,
        input  grant_ack,
        input  any_req
    );

endinterface

// File: rtl/rr_priority_arbiter_masked_priority_pick.sv
// Combinational highest-index picker over an optionally masked request
// vector. Returns the winner as one-hot and as binary index, plus whether
// any (masked) request was present.
module masked_priority_pick
    import rr_priority_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 16,
    parameter int IDX_WIDTH = clogb2(NUM_REQ - 1)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic                 mask_en,
    input  logic [NUM_REQ-1:0]   mask,
    output logic [NUM_REQ-1:0]   onehot,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 any
);

    logic [NUM_REQ-1:0] eff;

    assign eff = mask_en ? (req & mask) : req;
    assign any = |eff;

    // Scan upward so the highest set bit is the last one written and wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (eff[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/rr_priority_arbiter.sv
// Registered priority arbiter: samples req, presents one grant (one-hot and
// binary index) over out_valid/out_ready. Fixed mode: highest index wins.
// Round-robin mode: the last accepted winner drops to lowest priority.
module rr_priority_arbiter
    import rr_priority_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 16,
    parameter int IDX_WIDTH   = clogb2(NUM_REQ - 1),
    parameter int ROUND_ROBIN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_priority_arbiter_if.master bus,
    output state_t               state,
    output logic [IDX_WIDTH-1:0] ptr
);

    state_t               state_q;
    state_t               state_nxt;
    logic [NUM_REQ-1:0]   onehot_q;
    logic [NUM_REQ-1:0]   onehot_nxt;
    logic [IDX_WIDTH-1:0] idx_q;
    logic [IDX_WIDTH-1:0] idx_nxt;
    logic [IDX_WIDTH-1:0] ptr_q;
    logic [IDX_WIDTH-1:0] ptr_nxt;

    logic                 valid;
    logic                 accept;
    logic                 rr_en;
    logic [IDX_WIDTH-1:0] mask_base;
    logic [NUM_REQ-1:0]   mask;

    logic [NUM_REQ-1:0]   m_onehot;
    logic [IDX_WIDTH-1:0] m_idx;
    logic                 m_any;
    logic [NUM_REQ-1:0]   u_onehot;
    logic [IDX_WIDTH-1:0] u_idx;
    logic                 u_any;
    logic [NUM_REQ-1:0]   win_onehot;
    logic [IDX_WIDTH-1:0] win_idx;

    assign rr_en  = (ROUND_ROBIN != 0);
    assign valid  = (state_q == GRANT);
    assign accept = valid & bus.out_ready;

    // On an accept edge the grant being accepted already counts as the new
    // pointer, so a back-to-back load sees it as lowest priority.
    assign mask_base = accept ? idx_q : ptr_q;

    // Mask selects the requesters strictly below the pointer.
    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            mask[i] = (i < int'(mask_base));
        end
    end

    masked_priority_pick #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick_masked (
        .req     (bus.req),
        .mask_en (rr_en),
        .mask    (mask),
        .onehot  (m_onehot),
        .idx     (m_idx),
        .any     (m_any)
    );

    masked_priority_pick #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick_full (
        .req     (bus.req),
        .mask_en (1'b0),
        .mask    (mask),
        .onehot  (u_onehot),
        .idx     (u_idx),
        .any     (u_any)
    );

    // Below-pointer requesters win if any exist, otherwise wrap to the top.
    assign win_onehot = m_any ? m_onehot : u_onehot;
    assign win_idx    = m_any ? m_idx    : u_idx;

    // State, grant and pointer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            onehot_q <= '0;
            idx_q    <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_nxt;
            onehot_q <= onehot_nxt;
            idx_q    <= idx_nxt;
            ptr_q    <= ptr_nxt;
        end
    end

    // Next-state, grant load/hold/clear and pointer update on accept.
    always_comb begin
        state_nxt  = state_q;
        onehot_nxt = onehot_q;
        idx_nxt    = idx_q;
        ptr_nxt    = ptr_q;
        case (state_q)
            IDLE: begin
                if (u_any) begin
                    state_nxt  = GRANT;
                    onehot_nxt = win_onehot;
                    idx_nxt    = win_idx;
                end
            end
            GRANT: begin
                if (bus.out_ready) begin
                    if (rr_en) begin
                        ptr_nxt = idx_q;
                    end
                    if (u_any) begin
                        onehot_nxt = win_onehot;
                        idx_nxt    = win_idx;
                    end else begin
                        state_nxt  = IDLE;
                        onehot_nxt = '0;
                        idx_nxt    = '0;
                    end
                end
            end
            default: begin
                state_nxt  = IDLE;
                onehot_nxt = '0;
                idx_nxt    = '0;
            end
        endcase
    end

    assign bus.out_valid    = valid;
    assign bus.grant_onehot = onehot_q;
    assign bus.grant_idx    = idx_q;
    assign bus.grant_ack    = onehot_q & {NUM_REQ{accept}};
    assign bus.any_req      = u_any;

    assign state = state_q;
    assign ptr   = ptr_q;

endmodule

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
- Registered, parametrised priority arbiter. It is the sequential successor of the team's combinational priority encoder.
- Samples a request vector and issues one grant, as both one-hot and binary index, over a valid/ready handshake.
- Selectable fixed-priority mode (highest index wins) or round-robin mode (last winner drops to lowest priority).
- Used for bus/CSR arbitration and interrupt-source selection in the core.

Parameters:
- NUM_REQ, 16, number of requesters; legal range 2..64.
- IDX_WIDTH, clogb2(NUM_REQ-1), width of the binary grant index.
- ROUND_ROBIN, 1, 1 = rotating priority after each accepted grant; 0 = fixed priority, highest index wins.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  request vector; bit i high = requester i wants service.
- out_valid  out  1  a grant is presented.
- out_ready  in  1  consumer accepts the grant this cycle.
- grant_onehot  out  NUM_REQ  registered one-hot grant; all zero when out_valid=0.
- grant_idx  out  IDX_WIDTH  registered binary index of the granted requester; 0 when out_valid=0.
- grant_ack  out  NUM_REQ  combinational pulse, equal to grant_onehot & {NUM_REQ{out_valid & out_ready}}; tells requester i it was serviced.
- any_req  out  1  combinational OR of req.

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, grant_onehot=0, grant_idx=0, rotation pointer ptr=0. Reset overrides everything, including a grant being held mid-handshake; that grant is dropped.
- States:
  - IDLE: out_valid=0.
  - GRANT: out_valid=1; grant_onehot and grant_idx are held stable.
- IDLE -> GRANT: on an edge where |req=1. The grant is computed from req at that edge, so latency is one cycle from request to out_valid.
- GRANT -> GRANT, output held: on an edge where out_ready=0. Outputs do not change even if req changes or the granted bit drops. There is no withdrawal.
- GRANT, accept: on an edge where out_ready=1.
  - If |req=1 at that edge, the next grant is loaded back-to-back and the block stays in GRANT. This gives full throughput of one grant per cycle.
  - Otherwise the block goes to IDLE.
  - The req sampled at the accept edge includes the bit just serviced. Requesters must deassert on grant_ack or they will be re-arbitrated.
- Selection, fixed mode (ROUND_ROBIN=0): winner is the highest set index of req. ptr is unused and stays 0.
- Selection, round-robin mode:
  - Priority order, highest first: ptr-1, ptr-2, ..., 0, NUM_REQ-1, ..., ptr, with wrap modulo NUM_REQ.
  - ptr=0 gives NUM_REQ-1 down to 0, which matches fixed mode, so behaviour right after reset equals fixed mode.
  - On each accepted grant, ptr <= grant_idx, so the winner becomes lowest priority.
  - ptr is updated only on accept, never on load or while stalled.
- Implementation of the round-robin pick:
  - masked = req & ((1<<ptr)-1), i.e. bits below ptr.
  - If masked is non-zero, winner = highest set bit of masked.
  - Otherwise, winner = highest set bit of req.
  - No modulo arithmetic.
- Width rules: grant_idx is zero-extended to IDX_WIDTH. ptr is IDX_WIDTH bits wide. For non-power-of-2 NUM_REQ, ptr must never exceed NUM_REQ-1.
- Simultaneous events:
  - All requesters asserted: the round-robin rotation visits every index exactly once per NUM_REQ accepted grants.
  - Single requester: it wins every time regardless of ptr.
  - req=0 at an accept edge: go to IDLE; ptr still updates.
- Invariants:
  - grant_onehot has at most one bit set.
  - grant_onehot[grant_idx]=1 whenever out_valid=1.
  - out_valid is never deasserted without an accept or a reset.

Decomposition:
- Shared header file: clogb2 function and the GRANT/IDLE state encoding. The existing encoder also uses clogb2.
- One natural sub-module: masked_priority_pick.
  - Purely combinational.
  - Inputs: req, mask_en, mask.
  - Outputs: one-hot winner, binary index, any.
  - Instantiated twice (masked and unmasked), or once with a select.
- The top level holds the state register, ptr, output registers and handshake logic.

Test Plan:
- Reset/idle: NUM_REQ=8, ROUND_ROBIN=1, req=0 for 5 cycles after reset release -> out_valid=0, grant_onehot=0, grant_idx=0, any_req=0.
- Fixed priority: ROUND_ROBIN=0, req=8'b0010_0110 held, out_ready=1 -> grant_idx=5 on every cycle starting one cycle after req; ptr stays 0.
- Round-robin rotation: ROUND_ROBIN=1, req=8'hFF held, out_ready=1 -> grant_idx sequence 7,6,5,4,3,2,1,0,7,...; one grant per cycle, no bubbles.
- Stall hold: req=8'b1000_0001, out_ready=0 for 4 cycles, req changed to 8'b0000_0001 during the stall -> grant_idx stays 7 and grant_ack=0 throughout; out_ready=1 -> grant_ack=8'h80 that cycle, next grant_idx=0.
- Wrap/mask: ptr=2 (after a grant on 2 is accepted), req=8'b1000_1010 -> next grant_idx=1; after accept (ptr=1), req=8'b1000_1000 -> grant_idx=7 (wrap).
- Reset mid-handshake: out_valid=1 with grant_idx=4, rst_n=0 for 1 cycle -> next cycle out_valid=0, ptr=0; with req=8'h18 after release, the first grant is grant_idx=4 (fixed-equivalent order).
